// File: rtl/vb_bus_arbiter.sv
// vb_bus_arbiter: shares one external 8-bit memory bus between a core
// requester and a Wishbone slave window at {WB_BASE_HI, 16'hxxxx}.
// Each access runs IDLE -> SETUP -> WAIT (WAIT_CYCLES) -> ACCESS -> DONE.
// Optional feature macro: VB_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; when it is undefined the core has fixed priority.
module vb_bus_arbiter #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] WB_BASE_HI  = 16'h3000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [15:0] core_a,
    input  logic [7:0]  core_dout,
    output logic [7:0]  core_din,
    output logic        core_ack,
    output logic [15:0] ext_a,
    output logic [7:0]  ext_dout,
    output logic        ext_doe,
    output logic        ext_wr,
    input  logic [7:0]  ext_din
);

    typedef enum logic [2:0] {IDLE, SETUP, WAIT, ACCESS, DONE} state_t;

    // Last WAIT cycle index; unreachable when WAIT_CYCLES is 0 since SETUP skips WAIT.
    localparam logic [2:0] WAIT_LAST = 3'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       grant_wb;
    logic       acc_we;

    logic wb_stb;
    logic wb_hit;
    logic wb_miss;
    logic pick_wb;

    // Byte lanes and the upper write data never reach the 8-bit bus.
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:8]};

    assign wb_stb  = wbs_stb_i & wbs_cyc_i;
    assign wb_hit  = wb_stb & (wbs_adr_i[31:16] == WB_BASE_HI);
    assign wb_miss = wb_stb & (wbs_adr_i[31:16] != WB_BASE_HI);

`ifdef VB_ARB_ROUND_ROBIN_EN
    logic last_wb;

    // Grant selection: on contention the requester not served last wins.
    always_comb begin
        pick_wb = 1'b0;
        if (wb_hit && (!core_req || !last_wb))
            pick_wb = 1'b1;
    end

    // Round-robin pointer; starts as "Wishbone served last" so the core goes first.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            last_wb <= 1'b1;
        else if (state == IDLE && (core_req || wb_hit))
            last_wb <= pick_wb;
    end
`else
    // Grant selection: the core always wins on contention.
    always_comb begin
        pick_wb = 1'b0;
        if (wb_hit && !core_req)
            pick_wb = 1'b1;
    end
`endif

    // Access sequencer with registered bus and ack outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            grant_wb  <= 1'b0;
            acc_we    <= 1'b0;
            ext_a     <= 16'h0000;
            ext_dout  <= 8'h00;
            ext_doe   <= 1'b0;
            ext_wr    <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0000_0000;
            core_ack  <= 1'b0;
            core_din  <= 8'h00;
        end else begin
            wbs_ack_o <= 1'b0;
            core_ack  <= 1'b0;

            // Out-of-window cycles are answered directly and never reach the bus.
            if (wb_miss && !wbs_ack_o) begin
                wbs_ack_o <= 1'b1;
                wbs_dat_o <= 32'h0000_0000;
            end

            case (state)
                IDLE: begin
                    if (core_req || wb_hit) begin
                        grant_wb <= pick_wb;
                        acc_we   <= pick_wb ? wbs_we_i : core_we;
                        ext_a    <= pick_wb ? wbs_adr_i[15:0] : core_a;
                        ext_dout <= pick_wb ? (wbs_we_i ? wbs_dat_i[7:0] : 8'h00)
                                            : (core_we ? core_dout : 8'h00);
                        ext_doe  <= pick_wb ? wbs_we_i : core_we;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    cnt <= 3'd0;
                    if (WAIT_CYCLES == 0) begin
                        ext_wr <= acc_we;
                        state  <= ACCESS;
                    end else begin
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        ext_wr <= acc_we;
                        state  <= ACCESS;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ACCESS: begin
                    ext_wr  <= 1'b0;
                    ext_doe <= 1'b0;
                    state   <= DONE;
                    if (grant_wb) begin
                        // An abandoned Wishbone cycle still finishes on the bus but gets no ack.
                        wbs_ack_o <= wbs_cyc_i;
                        if (!acc_we)
                            wbs_dat_o <= {24'h000000, ext_din};
                    end else begin
                        core_ack <= 1'b1;
                        if (!acc_we)
                            core_din <= ext_din;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vb_bus_arbiter.sv
// tb_vb_bus_arbiter: directed-vector bench for vb_bus_arbiter.
// Main instance uses WAIT_CYCLES=2; a second instance uses WAIT_CYCLES=0.
module tb_vb_bus_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i, wbs_adr_i;
    logic        core_req, core_we;
    logic [15:0] core_a;
    logic [7:0]  core_dout;
    logic [7:0]  ext_din;

    logic        wbs_ack_o, core_ack, ext_doe, ext_wr;
    logic [31:0] wbs_dat_o;
    logic [7:0]  core_din, ext_dout;
    logic [15:0] ext_a;

    logic        d0_wbs_ack_o, d0_core_ack, d0_ext_doe, d0_ext_wr;
    logic [31:0] d0_wbs_dat_o;
    logic [7:0]  d0_core_din, d0_ext_dout;
    logic [15:0] d0_ext_a;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    vb_bus_arbiter #(.WAIT_CYCLES(2), .WB_BASE_HI(16'h3000)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .core_req(core_req), .core_we(core_we), .core_a(core_a), .core_dout(core_dout),
        .core_din(core_din), .core_ack(core_ack),
        .ext_a(ext_a), .ext_dout(ext_dout), .ext_doe(ext_doe), .ext_wr(ext_wr),
        .ext_din(ext_din)
    );

    vb_bus_arbiter #(.WAIT_CYCLES(0), .WB_BASE_HI(16'h3000)) dut0 (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(d0_wbs_ack_o), .wbs_dat_o(d0_wbs_dat_o),
        .core_req(core_req), .core_we(core_we), .core_a(core_a), .core_dout(core_dout),
        .core_din(d0_core_din), .core_ack(d0_core_ack),
        .ext_a(d0_ext_a), .ext_dout(d0_ext_dout), .ext_doe(d0_ext_doe), .ext_wr(d0_ext_wr),
        .ext_din(ext_din)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Steps until the selected ack appears (bounded); records ext_wr activity on the way.
    task automatic wait_ack(input bit wb, output int lat, output int wr_cnt,
                            output logic [15:0] a_wr, output logic [7:0] d_wr);
        lat = -1; wr_cnt = 0; a_wr = 16'h0; d_wr = 8'h0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (ext_wr) begin
                wr_cnt++;
                a_wr = ext_a;
                d_wr = ext_dout;
            end
            if (wb ? wbs_ack_o : core_ack) begin
                lat = i;
                break;
            end
        end
    endtask

    int          lat, wr_cnt, k, acks, wr0, ack0;
    logic [15:0] a_wr;
    logic [7:0]  d_wr;
    int          who [4];
    int          t_ack [4];

    initial begin
        wb_rst_i = 1'b1;
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 4'hF;
        wbs_dat_i = 32'h0; wbs_adr_i = 32'h0;
        core_req = 0; core_we = 0; core_a = 16'h0; core_dout = 8'h0; ext_din = 8'h0;
        step(); step();
        wb_rst_i = 1'b0;
        chk("rst_ext_a", 32'(ext_a), 32'h0);
        chk("rst_ext_doe", 32'(ext_doe), 32'h0);
        chk("rst_ext_wr", 32'(ext_wr), 32'h0);
        chk("rst_acks", {30'h0, core_ack, wbs_ack_o}, 32'h0);
        chk("rst_wbs_dat_o", wbs_dat_o, 32'h0);
        chk("rst_core_din", 32'(core_din), 32'h0);
        step();

        // Core write C000 <= 5A
        core_req = 1; core_we = 1; core_a = 16'hC000; core_dout = 8'h5A;
        step();
        chk("setup_ext_a", 32'(ext_a), 32'h0000C000);
        chk("setup_ext_doe", 32'(ext_doe), 32'h1);
        chk("setup_ext_wr", 32'(ext_wr), 32'h0);
        wait_ack(1'b0, lat, wr_cnt, a_wr, d_wr);
        chk("cw_latency", 32'(lat + 1), 32'd5);
        chk("cw_wr_cycles", 32'(wr_cnt), 32'd1);
        chk("cw_ext_a", 32'(a_wr), 32'h0000C000);
        chk("cw_ext_dout", 32'(d_wr), 32'h0000005A);
        chk("done_ext_doe", 32'(ext_doe), 32'h0);
        core_req = 0; core_we = 0;
        step();

        // Core read 1234 -> 3C
        core_req = 1; core_a = 16'h1234; ext_din = 8'h3C;
        wait_ack(1'b0, lat, wr_cnt, a_wr, d_wr);
        chk("cr_latency", 32'(lat), 32'd5);
        chk("cr_core_din", 32'(core_din), 32'h3C);
        chk("cr_no_wr", 32'(wr_cnt), 32'd0);
        core_req = 0; ext_din = 8'h00;
        step(); step();
        chk("cr_hold_core_din", 32'(core_din), 32'h3C);

        // Wishbone read 3000_0100 -> A7
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_0100; ext_din = 8'hA7;
        wait_ack(1'b1, lat, wr_cnt, a_wr, d_wr);
        chk("wr_latency", 32'(lat), 32'd5);
        chk("wr_dat_o", wbs_dat_o, 32'h0000_00A7);
        chk("wr_no_wr", 32'(wr_cnt), 32'd0);
        chk("wr_ext_a", 32'(ext_a), 32'h0000_0100);
        wbs_stb_i = 0; wbs_cyc_i = 0;
        step();

        // Out-of-window Wishbone access
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_adr_i = 32'h2000_0000;
        step();
        chk("miss_ack", 32'(wbs_ack_o), 32'h1);
        chk("miss_dat_o", wbs_dat_o, 32'h0);
        chk("miss_bus", {30'h0, ext_doe, ext_wr}, 32'h0);
        wbs_stb_i = 0; wbs_cyc_i = 0;
        step();
        chk("miss_bus_after", {30'h0, ext_doe, ext_wr}, 32'h0);

        // Contention: both requesting continuously
        core_req = 1; core_we = 1; core_a = 16'h0001; core_dout = 8'h11;
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_0200;
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            step();
            if (core_ack) begin
                who[k] = 0; t_ack[k] = i; k++;
            end else if (wbs_ack_o) begin
                who[k] = 1; t_ack[k] = i; k++;
            end
        end
        chk("arb_count", 32'(k), 32'd4);
`ifdef VB_ARB_ROUND_ROBIN_EN
        chk("arb_g0", 32'(who[0]), 32'd0);
        chk("arb_g1", 32'(who[1]), 32'd1);
        chk("arb_g2", 32'(who[2]), 32'd0);
        chk("arb_g3", 32'(who[3]), 32'd1);
`else
        chk("arb_g0", 32'(who[0]), 32'd0);
        chk("arb_g1", 32'(who[1]), 32'd0);
        chk("arb_g2", 32'(who[2]), 32'd0);
        chk("arb_g3", 32'(who[3]), 32'd0);
`endif
        chk("arb_period", 32'(t_ack[1] - t_ack[0]), 32'd6);
        core_req = 0; core_we = 0;
        wait_ack(1'b1, lat, wr_cnt, a_wr, d_wr);
        chk("arb_wb_after_drop", 32'(lat), 32'd6);
        wbs_stb_i = 0; wbs_cyc_i = 0;
        step();

        // Reset during WAIT of a core write
        core_req = 1; core_we = 1; core_a = 16'h5555; core_dout = 8'hAA;
        step(); step();
        chk("pre_rst_doe", 32'(ext_doe), 32'h1);
        wb_rst_i = 1;
        step();
        wb_rst_i = 0; core_req = 0; core_we = 0;
        chk("rstw_ext_a", 32'(ext_a), 32'h0);
        chk("rstw_ext_dout", 32'(ext_dout), 32'h0);
        chk("rstw_doe_wr", {30'h0, ext_doe, ext_wr}, 32'h0);
        chk("rstw_wbs_dat_o", wbs_dat_o, 32'h0);
        chk("rstw_core_din", 32'(core_din), 32'h0);
        acks = 0; wr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (core_ack || wbs_ack_o) acks++;
            if (ext_wr) wr_cnt++;
        end
        chk("rstw_no_ack", 32'(acks), 32'd0);
        chk("rstw_no_wr", 32'(wr_cnt), 32'd0);

        // WAIT_CYCLES=0: Wishbone write abandoned during SETUP
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h3000_0042;
        wbs_dat_i = 32'h0000_0099;
        step();
        chk("w0_setup_doe", 32'(d0_ext_doe), 32'h1);
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        wr0 = 0; ack0 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (d0_ext_wr) begin
                wr0++;
                chk("w0_ext_dout", 32'(d0_ext_dout), 32'h99);
            end
            if (d0_wbs_ack_o) ack0++;
        end
        chk("w0_wr_once", 32'(wr0), 32'd1);
        chk("w0_no_ack", 32'(ack0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
